subsurf_stage_seq: RTL and testbench

//  Parametrised pipeline-stage sequencer and RAM-port arbiter for the subdivision-surface top.

---
 rtl/subsurf_pkg.sv | 25 ++
 rtl/subsurf_ram_mux.sv | 40 ++++
 rtl/subsurf_stage_seq.sv | 208 ++++++++++++++++++++
 tb/tb_subsurf_stage_seq.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/subsurf_pkg.sv
// Shared types and index constants for the subdivision-surface stage sequencer.
package subsurf_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        DONE   = 2'd3
    } seq_state_e;

    localparam int unsigned STG_NEIGHBOR = 0;
    localparam int unsigned STG_AVERAGER = 1;

    localparam int unsigned RAM_OBJ = 0;
    localparam int unsigned RAM_NBR = 1;
    localparam int unsigned RAM_RES = 2;

    localparam int unsigned CNT_W = 32;

    // A stage owns the RAM ports only while it is launching or being waited on.
    function automatic logic owns_ram(input seq_state_e s);
        return (s == LAUNCH) || (s == WAIT);
    endfunction

endpackage

// File: rtl/subsurf_ram_mux.sv
// Combinational NUM_STAGES:1 RAM request bundle mux; all outputs forced to 0 when not valid.
module subsurf_ram_mux
    import subsurf_pkg::*;
#(
    parameter int unsigned NUM_STAGES = 3,
    parameter int unsigned NUM_RAMS   = 3,
    parameter int unsigned ADDR_W     = 9,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned WE_W       = 4,
    parameter int unsigned SEL_W      = 2
) (
    input  logic                                 valid,
    input  logic [SEL_W-1:0]                     sel,
    input  logic [NUM_STAGES*NUM_RAMS-1:0]        s_en,
    input  logic [NUM_STAGES*NUM_RAMS*ADDR_W-1:0] s_a,
    input  logic [NUM_STAGES*NUM_RAMS*WE_W-1:0]   s_we,
    input  logic [NUM_STAGES*NUM_RAMS*DATA_W-1:0] s_di,
    output logic [NUM_RAMS-1:0]                   en,
    output logic [NUM_RAMS*ADDR_W-1:0]            a,
    output logic [NUM_RAMS*WE_W-1:0]              we,
    output logic [NUM_RAMS*DATA_W-1:0]            di
);

    // Bundles are stage-major, so each stage's request is one contiguous slice.
    always_comb begin : bundle_mux
        en = '0;
        a  = '0;
        we = '0;
        di = '0;
        for (int k = 0; k < NUM_STAGES; k++) begin
            if (valid && (sel == SEL_W'(k))) begin
                en = s_en[k*NUM_RAMS +: NUM_RAMS];
                a  = s_a[k*NUM_RAMS*ADDR_W +: NUM_RAMS*ADDR_W];
                we = s_we[k*NUM_RAMS*WE_W +: NUM_RAMS*WE_W];
                di = s_di[k*NUM_RAMS*DATA_W +: NUM_RAMS*DATA_W];
            end
        end
    end

endmodule

// File: rtl/subsurf_stage_seq.sv
// In-order stage sequencer and shared RAM-port arbiter for the subdivision-surface top.
// Optional watchdog abort is built when SUBSURF_SEQ_TIMEOUT_EN is defined.
module subsurf_stage_seq
    import subsurf_pkg::*;
#(
    parameter int unsigned NUM_STAGES = 3,
    parameter int unsigned NUM_RAMS   = 3,
    parameter int unsigned ADDR_W     = 9,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned WE_W       = 4,
    parameter int unsigned START_LEN  = 3,
    parameter int unsigned TIMEOUT    = 4096
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start,
    input  logic [NUM_STAGES-1:0]                 stage_mask,
    input  logic [CNT_W-1:0]                      vertex_cnt_i,
    input  logic [CNT_W-1:0]                      face_cnt_i,
    output logic [CNT_W-1:0]                      vertex_cnt_o,
    output logic [CNT_W-1:0]                      face_cnt_o,
    output logic [NUM_STAGES-1:0]                 stage_start,
    input  logic [NUM_STAGES-1:0]                 stage_busy,
    input  logic [NUM_STAGES*NUM_RAMS-1:0]        s_en,
    input  logic [NUM_STAGES*NUM_RAMS*ADDR_W-1:0] s_a,
    input  logic [NUM_STAGES*NUM_RAMS*WE_W-1:0]   s_we,
    input  logic [NUM_STAGES*NUM_RAMS*DATA_W-1:0] s_di,
    output logic [NUM_RAMS-1:0]                   en,
    output logic [NUM_RAMS*ADDR_W-1:0]            a,
    output logic [NUM_RAMS*WE_W-1:0]              we,
    output logic [NUM_RAMS*DATA_W-1:0]            di,
    output logic                                  busy,
    output logic                                  done,
    output logic                                  err
);

    localparam int unsigned CUR_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
    localparam int unsigned LEN_W = (START_LEN > 1) ? $clog2(START_LEN) : 1;

    if ((START_LEN < 1) || (TIMEOUT < 1)) begin : g_param_check
        $error("subsurf_stage_seq: START_LEN and TIMEOUT must be >= 1");
    end

    seq_state_e            state_q, state_d;
    logic [CUR_W-1:0]      cur_q, cur_d;
    logic [LEN_W-1:0]      len_q, len_d;
    logic [NUM_STAGES-1:0] mask_q, mask_d;
    logic [CNT_W-1:0]      vcnt_d, fcnt_d;
    logic [NUM_STAGES-1:0] stage_start_d;
    logic                  busy_d, done_d;

    logic [CUR_W-1:0]      first_idx, next_idx;
    logic                  next_found, cur_busy;

`ifdef SUBSURF_SEQ_TIMEOUT_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT + 1);
    logic [WD_W-1:0] wd_q;
    logic            err_d;
`endif

    // Lowest set bit of the incoming mask, lowest latched bit above cur, busy of cur.
    always_comb begin : bit_search
        first_idx  = '0;
        next_idx   = '0;
        next_found = 1'b0;
        cur_busy   = 1'b0;
        for (int k = NUM_STAGES - 1; k >= 0; k--) begin
            if (stage_mask[k]) begin
                first_idx = CUR_W'(k);
            end
            if (mask_q[k] && (k > int'(cur_q))) begin
                next_idx   = CUR_W'(k);
                next_found = 1'b1;
            end
            if (cur_q == CUR_W'(k)) begin
                cur_busy = stage_busy[k];
            end
        end
    end

    always_comb begin : next_state
        state_d = state_q;
        cur_d   = cur_q;
        len_d   = len_q;
        mask_d  = mask_q;
        vcnt_d  = vertex_cnt_o;
        fcnt_d  = face_cnt_o;
`ifdef SUBSURF_SEQ_TIMEOUT_EN
        err_d   = err;
`endif
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    mask_d = stage_mask;
                    vcnt_d = vertex_cnt_i;
                    fcnt_d = face_cnt_i;
                    len_d  = '0;
`ifdef SUBSURF_SEQ_TIMEOUT_EN
                    err_d  = 1'b0;
`endif
                    if (|stage_mask) begin
                        state_d = LAUNCH;
                        cur_d   = first_idx;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            LAUNCH: begin
                if (len_q == LEN_W'(START_LEN - 1)) begin
                    state_d = WAIT;
                    len_d   = '0;
                end else begin
                    len_d = len_q + LEN_W'(1);
                end
            end
            WAIT: begin
                if (!cur_busy) begin
                    if (next_found) begin
                        state_d = LAUNCH;
                        cur_d   = next_idx;
                    end else begin
                        state_d = DONE;
                    end
                end
`ifdef SUBSURF_SEQ_TIMEOUT_EN
                else if (wd_q == WD_W'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end
`endif
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Registered outputs are derived from the next state so they line up with it.
        for (int k = 0; k < NUM_STAGES; k++) begin
            stage_start_d[k] = (state_d == LAUNCH) && (cur_d == CUR_W'(k));
        end
        busy_d = owns_ram(state_d);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin : seq_regs
        if (rst) begin
            state_q      <= IDLE;
            cur_q        <= '0;
            len_q        <= '0;
            mask_q       <= '0;
            vertex_cnt_o <= '0;
            face_cnt_o   <= '0;
            stage_start  <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            state_q      <= state_d;
            cur_q        <= cur_d;
            len_q        <= len_d;
            mask_q       <= mask_d;
            vertex_cnt_o <= vcnt_d;
            face_cnt_o   <= fcnt_d;
            stage_start  <= stage_start_d;
            busy         <= busy_d;
            done         <= done_d;
        end
    end

`ifdef SUBSURF_SEQ_TIMEOUT_EN
    // Watchdog counts consecutive WAIT cycles; any other state clears it.
    always_ff @(posedge clk) begin : watchdog
        if (rst) begin
            wd_q <= '0;
            err  <= 1'b0;
        end else begin
            wd_q <= (state_q == WAIT) ? wd_q + WD_W'(1) : '0;
            err  <= err_d;
        end
    end
`else
    assign err = 1'b0;
`endif

    subsurf_ram_mux #(
        .NUM_STAGES (NUM_STAGES),
        .NUM_RAMS   (NUM_RAMS),
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .WE_W       (WE_W),
        .SEL_W      (CUR_W)
    ) u_ram_mux (
        .valid (owns_ram(state_q)),
        .sel   (cur_q),
        .s_en  (s_en),
        .s_a   (s_a),
        .s_we  (s_we),
        .s_di  (s_di),
        .en    (en),
        .a     (a),
        .we    (we),
        .di    (di)
    );

endmodule

// File: tb/tb_subsurf_stage_seq.sv
// Self-checking bench for subsurf_stage_seq: randomized runs against a timeline model of the sequencer.
module tb_subsurf_stage_seq;

    localparam int unsigned NS = 3;
    localparam int unsigned NR = 3;
    localparam int unsigned AW = 9;
    localparam int unsigned DW = 32;
    localparam int unsigned WW = 4;
    localparam int unsigned SL = 3;
    localparam int unsigned TO = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst, start;
    logic [NS-1:0]      stage_mask, stage_start, stage_busy;
    logic [31:0]        vin, fin, vout, fout;
    logic [NS*NR-1:0]    s_en;
    logic [NS*NR*AW-1:0] s_a;
    logic [NS*NR*WW-1:0] s_we;
    logic [NS*NR*DW-1:0] s_di;
    logic [NR-1:0]       en;
    logic [NR*AW-1:0]    a;
    logic [NR*WW-1:0]    we;
    logic [NR*DW-1:0]    di;
    logic                busy, done, err;

    int errors = 0;
    int checks = 0;

    int          hold[NS];
    int          bcnt[NS];
    logic [NS-1:0] prev_ss;
    logic [31:0] exp_v, exp_f;
    logic        exp_err;

    subsurf_stage_seq #(
        .NUM_STAGES(NS), .NUM_RAMS(NR), .ADDR_W(AW), .DATA_W(DW),
        .WE_W(WW), .START_LEN(SL), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .stage_mask(stage_mask),
        .vertex_cnt_i(vin), .face_cnt_i(fin), .vertex_cnt_o(vout), .face_cnt_o(fout),
        .stage_start(stage_start), .stage_busy(stage_busy),
        .s_en(s_en), .s_a(s_a), .s_we(s_we), .s_di(s_di),
        .en(en), .a(a), .we(we), .di(di),
        .busy(busy), .done(done), .err(err)
    );

    // Behavioural stage: on a new start pulse it raises busy for hold[k] cycles.
    task automatic stage_step();
        for (int k = 0; k < NS; k++) begin
            if (stage_start[k] && !prev_ss[k]) bcnt[k] = hold[k];
            else if (bcnt[k] > 0) bcnt[k]--;
            stage_busy[k] = (bcnt[k] > 0);
        end
        prev_ss = stage_start;
    endtask

    task automatic stage_clear();
        for (int k = 0; k < NS; k++) bcnt[k] = 0;
        stage_busy = '0;
        prev_ss = '0;
    endtask

    task automatic randomize_bundles(input bit ones);
        for (int i = 0; i < NS*NR; i++) begin
            s_en[i]           = ones ? 1'b1 : 1'($urandom_range(0, 1));
            s_a[i*AW +: AW]   = AW'($urandom);
            s_we[i*WW +: WW]  = ones ? '1 : WW'($urandom);
            s_di[i*DW +: DW]  = $urandom;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; stage_mask = '1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++; if (stage_start !== '0) begin errors++; $display("FAIL reset stage_start got=%b exp=0", stage_start); end
        checks++; if ({busy, done, err} !== 3'b000) begin errors++; $display("FAIL reset flags got=%b exp=000", {busy, done, err}); end
        checks++; if ({vout, fout} !== 64'd0) begin errors++; $display("FAIL reset counts got=%h exp=0", {vout, fout}); end
        checks++; if ({en, we} !== '0) begin errors++; $display("FAIL reset en_we got=%h exp=0", {en, we}); end
        checks++; if ({a, di} !== '0) begin errors++; $display("FAIL reset a_di got=%h exp=0", {a, di}); end
        rst = 1'b0; start = 1'b0; stage_mask = '0;
        exp_v = '0; exp_f = '0; exp_err = 1'b0;
    endtask

    // One run: timeline model gives launch cycle of each enabled stage and the done cycle.
    task automatic test_run(input string name, input logic [NS-1:0] mask,
                            input int h0, input int h1, input int h2,
                            input bit noise, input bit ones, input int limit);
        int L[NS];
        int stg[NS];
        int n, t, d, last, oi, o, nend;
        bit to_hit;
        logic [NS-1:0]    exp_ss;
        logic [NR-1:0]    exp_en;
        logic [NR*AW-1:0] exp_a;
        logic [NR*WW-1:0] exp_we;
        logic [NR*DW-1:0] exp_di;
        logic             exp_busy, exp_done, exp_err_now;

        hold[0] = h0; hold[1] = h1; hold[2] = h2;
        n = 0; t = 1; d = 1; to_hit = 1'b0;
        for (int k = 0; k < NS; k++) if (mask[k]) begin stg[n] = k; n++; end
        for (int i = 0; i < n; i++) begin
            L[i] = t;
`ifdef SUBSURF_SEQ_TIMEOUT_EN
            if (hold[stg[i]] > int'(SL + TO) - 1) begin
                d = t + int'(SL + TO); to_hit = 1'b1; n = i + 1; break;
            end
`endif
            t = t + hold[stg[i]] + 1;
            d = t;
        end

        stage_mask = mask; vin = $urandom; fin = $urandom; start = 1'b1;
        exp_v = vin; exp_f = fin;
        last = (d + 2 < limit) ? d + 2 : limit;
        for (int r = 1; r <= last; r++) begin
            @(posedge clk); #1;
            oi = -1;
            for (int i = 0; i < n; i++) begin
                nend = (i + 1 < n) ? L[i+1] : d;
                if (r >= L[i] && r < nend) oi = i;
            end
            exp_ss = '0; exp_en = '0; exp_a = '0; exp_we = '0; exp_di = '0;
            if (oi >= 0) begin
                o = stg[oi];
                if (r < L[oi] + int'(SL)) exp_ss = NS'(1) << o;
                exp_en = s_en[o*NR +: NR];
                exp_a  = s_a[o*NR*AW +: NR*AW];
                exp_we = s_we[o*NR*WW +: NR*WW];
                exp_di = s_di[o*NR*DW +: NR*DW];
            end
            exp_busy = (n > 0) && (r < d);
            exp_done = (r == d);
            exp_err_now = to_hit && (r >= d);

            checks++; if (stage_start !== exp_ss) begin errors++; $display("FAIL %s stage_start r=%0d got=%b exp=%b", name, r, stage_start, exp_ss); end
            checks++; if (busy !== exp_busy) begin errors++; $display("FAIL %s busy r=%0d got=%b exp=%b", name, r, busy, exp_busy); end
            checks++; if (done !== exp_done) begin errors++; $display("FAIL %s done r=%0d got=%b exp=%b", name, r, done, exp_done); end
            checks++; if (err !== exp_err_now) begin errors++; $display("FAIL %s err r=%0d got=%b exp=%b", name, r, err, exp_err_now); end
            checks++; if ({vout, fout} !== {exp_v, exp_f}) begin errors++; $display("FAIL %s counts r=%0d got=%h exp=%h", name, r, {vout, fout}, {exp_v, exp_f}); end
            checks++; if (en !== exp_en) begin errors++; $display("FAIL %s en r=%0d got=%b exp=%b", name, r, en, exp_en); end
            checks++; if (we !== exp_we) begin errors++; $display("FAIL %s we r=%0d got=%h exp=%h", name, r, we, exp_we); end
            checks++; if (a !== exp_a) begin errors++; $display("FAIL %s a r=%0d got=%h exp=%h", name, r, a, exp_a); end
            checks++; if (di !== exp_di) begin errors++; $display("FAIL %s di r=%0d got=%h exp=%h", name, r, di, exp_di); end

            start = (noise && r < d) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (noise) begin stage_mask = NS'($urandom); vin = $urandom; fin = $urandom; end
            stage_step();
            randomize_bundles(ones);
        end
        exp_err = to_hit;
    endtask

    // Reset while stage 1 is in WAIT: everything must drop on the next cycle.
    task automatic test_reset_midrun();
        hold[0] = 4; hold[1] = 8; hold[2] = 4;
        stage_mask = 3'b011; vin = $urandom; fin = $urandom; start = 1'b1;
        for (int r = 1; r <= 12; r++) begin
            @(posedge clk); #1;
            if (r == 6) begin
                checks++; if (stage_start !== 3'b010) begin errors++; $display("FAIL midrun launch1 got=%b exp=010", stage_start); end
            end
            if (r == 10) begin
                checks++; if ({busy, stage_start} !== 4'b1000) begin errors++; $display("FAIL midrun wait1 got=%b exp=1000", {busy, stage_start}); end
            end
            if (r == 11) begin
                checks++; if ({busy, done, err, stage_start} !== 6'd0) begin errors++; $display("FAIL midrun flags got=%b exp=0", {busy, done, err, stage_start}); end
                checks++; if ({vout, fout} !== 64'd0) begin errors++; $display("FAIL midrun counts got=%h exp=0", {vout, fout}); end
                checks++; if ({en, we, a, di} !== '0) begin errors++; $display("FAIL midrun mux got=%h exp=0", {en, we, a, di}); end
            end
            if (r == 12) begin
                checks++; if ({busy, done, en} !== '0) begin errors++; $display("FAIL midrun idle got=%b exp=0", {busy, done, en}); end
            end
            start = 1'b0;
            rst = (r == 10);
            if (r >= 10) stage_clear(); else stage_step();
            randomize_bundles(1'b1);
        end
        exp_v = '0; exp_f = '0; exp_err = 1'b0;
    endtask

    task automatic test_watchdog();
        stage_clear();
`ifdef SUBSURF_SEQ_TIMEOUT_EN
        test_run("watchdog", 3'b001, 1000000, 5, 5, 1'b0, 1'b0, 100);
        stage_clear();
        test_run("post_watchdog", 3'b010, 4, 4, 4, 1'b0, 1'b0, 1000);
`else
        test_run("no_watchdog", 3'b001, 1000000, 5, 5, 1'b0, 1'b0, 40);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        stage_clear();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL no_watchdog reset busy got=%b exp=0", busy); end
        exp_v = '0; exp_f = '0;
`endif
    endtask

    initial begin : timeout_guard
        #1000000;
        $display("FAIL global_timeout sim time exceeded");
        $fatal(1, "bench timeout");
    end

    initial begin : main
        rst = 1'b1; start = 1'b0; stage_mask = '0; vin = '0; fin = '0;
        for (int k = 0; k < NS; k++) hold[k] = int'(SL);
        stage_clear();
        randomize_bundles(1'b0);

        test_reset();
        test_run("basic", 3'b011, 10, 5, 6, 1'b0, 1'b0, 1000);
        test_run("skip", 3'b101, 6, 6, 7, 1'b0, 1'b0, 1000);
        test_run("mux_isolation", 3'b010, 5, 7, 5, 1'b0, 1'b1, 1000);
        test_run("empty_mask", 3'b000, 5, 5, 5, 1'b0, 1'b1, 1000);
        test_run("min_wait", 3'b111, int'(SL), int'(SL), int'(SL), 1'b0, 1'b0, 1000);
        test_reset_midrun();
        test_run("retrigger", 3'b110, 5, 6, 9, 1'b1, 1'b0, 1000);
        for (int i = 0; i < 10; i++) begin
            test_run("random", NS'($urandom_range(0, 7)),
                     $urandom_range(SL, SL + 8), $urandom_range(SL, SL + 8),
                     $urandom_range(SL, SL + 8), 1'($urandom_range(0, 1)), 1'b0, 1000);
        end
        test_watchdog();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
